// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave front-end driving a split read/write strobe memory port.
// Define AHB_SLAVE_ERR_EN to reject oversize/misaligned transfers with a two-cycle ERROR response.
module ahb_slave_ctrl #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   HSEL,
    input  logic [ADDR_BITS-1:0]   HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [DATA_BITS-1:0]   HWDATA,
    input  logic                   HREADY,
    output logic [DATA_BITS-1:0]   HRDATA,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic                   WR,
    output logic [ADDR_BITS-1:0]   ADDR_WR,
    output logic [DATA_BITS-1:0]   DIN,
    output logic [DATA_BITS/8-1:0] BSEL,
    output logic                   RD,
    output logic [ADDR_BITS-1:0]   ADDR_RD,
    input  logic [DATA_BITS-1:0]   DOUT,
    output logic [2:0]             fsm_state
);
    localparam int BX = DATA_BITS / 8;
    localparam int LB = $clog2(BX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        RDATA  = 3'd2,
        RSTALL = 3'd3
`ifdef AHB_SLAVE_ERR_EN
        ,
        ERR1   = 3'd4,
        ERR2   = 3'd5
`endif
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] addr_wr_q;
    logic [ADDR_BITS-1:0] addr_rd_q;
    logic [BX-1:0]        bsel_q;
    logic                 hready_q;
`ifdef AHB_SLAVE_ERR_EN
    logic                 hresp_q;
`endif

    logic          take;
    logic          is_read;
    logic          hazard;
    logic          bad;
    logic [BX-1:0] lanes;

    // A lane is on when it falls in the same size-aligned block as the address.
    function automatic logic [BX-1:0] lane_mask(input logic [2:0] size, input logic [LB-1:0] off);
        logic [BX-1:0] m;
        int sz;
        int o;
        sz = int'(size);
        o  = int'(off);
        for (int i = 0; i < BX; i++)
            m[i] = (sz >= LB) || ((i >> sz) == (o >> sz));
        return m;
    endfunction

    // hready_q is low only in wait states, so it also blocks accepts there.
    assign take    = HSEL & HTRANS[1] & HREADY & hready_q;
    assign is_read = take & ~HWRITE & ~bad;
    assign hazard  = is_read && (state == WDATA) &&
                     (HADDR[ADDR_BITS-1:LB] == addr_wr_q[ADDR_BITS-1:LB]);
    assign lanes   = lane_mask(HSIZE, HADDR[LB-1:0]);

`ifdef AHB_SLAVE_ERR_EN
    assign bad   = (int'(HSIZE) > LB) ||
                   ((int'(HADDR[LB-1:0]) & ((1 << int'(HSIZE)) - 1)) != 0);
    assign HRESP = hresp_q;
`else
    assign bad   = 1'b0;
    assign HRESP = 1'b0;
`endif

    assign HRDATA    = DOUT;
    assign DIN       = HWDATA;
    assign HREADYOUT = hready_q;
    assign ADDR_WR   = addr_wr_q;
    assign BSEL      = bsel_q;
    assign WR        = reset && (state == WDATA);
    assign RD        = reset && ((state == RSTALL) || (is_read && !hazard));
    assign ADDR_RD   = (state == RSTALL) ? addr_rd_q : HADDR;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            hready_q  <= 1'b1;
            addr_wr_q <= '0;
            addr_rd_q <= '0;
            bsel_q    <= '0;
`ifdef AHB_SLAVE_ERR_EN
            hresp_q   <= 1'b0;
`endif
        end else begin
            hready_q <= 1'b1;
`ifdef AHB_SLAVE_ERR_EN
            hresp_q  <= 1'b0;
`endif
            if (take) begin
`ifdef AHB_SLAVE_ERR_EN
                if (bad) begin
                    state    <= ERR1;
                    hready_q <= 1'b0;
                    hresp_q  <= 1'b1;
                end else
`endif
                if (HWRITE) begin
                    state     <= WDATA;
                    addr_wr_q <= HADDR;
                    bsel_q    <= lanes;
                end else if (hazard) begin
                    // Re-issue the read once the pending write has landed.
                    state     <= RSTALL;
                    hready_q  <= 1'b0;
                    addr_rd_q <= HADDR;
                end else begin
                    state <= RDATA;
                end
            end else begin
                case (state)
                    RSTALL:  state <= RDATA;
`ifdef AHB_SLAVE_ERR_EN
                    ERR1: begin
                        state   <= ERR2;
                        hresp_q <= 1'b1;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Directed bench for ahb_slave_ctrl: drives an AHB-Lite master, models the memory stub,
// and checks every cycle against a transfer-level model of the bus and memory contents.
module tb_ahb_slave_ctrl;
    localparam int AB = 16;
    localparam int DB = 32;
    localparam int BX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          hsel = 1'b0;
    logic [AB-1:0] haddr = '0;
    logic [1:0]    htrans = 2'd0;
    logic          hwrite = 1'b0;
    logic [2:0]    hsize = 3'd0;
    logic [DB-1:0] hwdata = '0;
    logic          hready;
    logic [DB-1:0] hrdata;
    logic          hreadyout;
    logic          hresp;
    logic          wr;
    logic [AB-1:0] addr_wr;
    logic [DB-1:0] din;
    logic [BX-1:0] bsel;
    logic          rd;
    logic [AB-1:0] addr_rd;
    logic [DB-1:0] dout = '0;
    logic [2:0]    fsm_state;

    int checks = 0;
    int failures = 0;
    logic [DB-1:0] exp_q[$];
    logic [BX-1:0] bsel_q[$];

    // clock / reset
    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb_slave_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp), .WR(wr),
        .ADDR_WR(addr_wr), .DIN(din), .BSEL(bsel), .RD(rd), .ADDR_RD(addr_rd),
        .DOUT(dout), .fsm_state(fsm_state)
    );

    // memory stub: registered read, byte-enabled write
    logic [DB-1:0] smem [0:255];
    initial for (int i = 0; i < 256; i++) smem[i] = '0;

    always @(posedge clk) begin
        logic [DB-1:0] m;
        if (!reset) dout <= '0;
        else if (rd) dout <= smem[addr_rd[9:2]];
        if (wr) begin
            m = smem[addr_wr[9:2]];
            for (int i = 0; i < BX; i++)
                if (bsel[i]) m[8*i +: 8] = din[8*i +: 8];
            smem[addr_wr[9:2]] <= m;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // scoreboard model: byte memory plus the data phase currently on the bus
    logic [7:0]    exp_mem [0:1023];
    bit            started = 0;
    bit            rst_edge = 0;
    bit            dp_write = 0;
    bit            dp_read = 0;
    bit            dp_err = 0;
    int            dp_waits = 0;
    logic [AB-1:0] dp_addr = '0;
    logic [2:0]    dp_size = '0;
    int both_cnt = 0, stall_cnt = 0, resp_cnt = 0, acc_cnt = 0;

    function automatic logic [BX-1:0] model_lanes(input logic [AB-1:0] a, input logic [2:0] s);
        logic [BX-1:0] r;
        int n;
        int start;
        n = 1 << int'(s);
        if (n >= BX) return '1;
        start = (int'(a) % BX) / n * n;
        r = BX'(((1 << n) - 1) << start);
        return r;
    endfunction

    function automatic logic [DB-1:0] model_word(input logic [AB-1:0] a);
        logic [DB-1:0] w;
        int base;
        base = int'(a[9:0]) & ~(BX - 1);
        for (int i = 0; i < BX; i++) w[8*i +: 8] = exp_mem[base + i];
        return w;
    endfunction

    always @(negedge clk) begin
        bit exp_ready, acc, bad, haz, exp_wr, exp_rd;
        logic [BX-1:0] lm;
        int base;
        exp_ready = (dp_waits == 0);
        acc = reset && hsel && htrans[1] && exp_ready;
        bad = 1'b0;
`ifdef AHB_SLAVE_ERR_EN
        bad = acc && ((hsize > 3'd2) || ((int'(haddr) & ((1 << int'(hsize)) - 1)) != 0));
`endif
        haz = acc && !hwrite && !bad && dp_write && (haddr[AB-1:2] == dp_addr[AB-1:2]);
        exp_wr = reset && dp_write;
        exp_rd = reset && ((acc && !hwrite && !bad && !haz) || (dp_read && dp_waits > 0));
        if (started) begin
            check("hreadyout", hreadyout, exp_ready);
            check("hresp", hresp, dp_err);
            check("wr", wr, exp_wr);
            check("rd", rd, exp_rd);
            if (rst_edge) begin
                check("bsel_rst", bsel, 0);
                check("addr_wr_rst", addr_wr, 0);
                check("hrdata_rst", hrdata, 0);
            end
            if (exp_wr) begin
                check("addr_wr", addr_wr, dp_addr);
                check("bsel", bsel, model_lanes(dp_addr, dp_size));
                check("din", din, hwdata);
                if (bsel_q.size() > 0) check("bsel_lit", bsel, bsel_q.pop_front());
            end
            if (exp_rd) check("addr_rd", addr_rd, (dp_read && dp_waits > 0) ? dp_addr : haddr);
            if (reset && dp_read && exp_ready) begin
                check("hrdata", hrdata, model_word(dp_addr));
                if (exp_q.size() > 0) check("hrdata_lit", hrdata, exp_q.pop_front());
            end
            if (reset) begin
                if (wr && rd) both_cnt++;
                if (!hreadyout) stall_cnt++;
                if (hresp) resp_cnt++;
                if (wr || rd) acc_cnt++;
            end
        end
        // advance the model to what the coming clock edge does
        if (!reset) begin
            started = 1;
            rst_edge = 1;
            dp_write = 0;
            dp_read = 0;
            dp_err = 0;
            dp_waits = 0;
        end else if (started) begin
            rst_edge = 0;
            if (dp_write) begin
                lm = model_lanes(dp_addr, dp_size);
                base = int'(dp_addr[9:0]) & ~(BX - 1);
                for (int i = 0; i < BX; i++)
                    if (lm[i]) exp_mem[base + i] = hwdata[8*i +: 8];
            end
            if (exp_ready) begin
                dp_write = acc && hwrite && !bad;
                dp_read  = acc && !hwrite && !bad;
                dp_err   = bad;
                dp_waits = (haz || bad) ? 1 : 0;
                dp_addr  = haddr;
                dp_size  = hsize;
            end else begin
                dp_waits--;
            end
        end
    end

    // driver tasks
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!hreadyout && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [1:0] tr, input logic wrt, input logic [AB-1:0] a,
                        input logic [2:0] s, input logic [DB-1:0] d);
        hsel = 1'b1;
        htrans = tr;
        hwrite = wrt;
        haddr = a;
        hsize = s;
        wait_accept();
        if (wrt) hwdata = d;
    endtask

    task automatic idle(input int n);
        hsel = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic noise(input int n);
        repeat (n) begin
            haddr = AB'($urandom_range(0, 16'hFFFF));
            hwrite = 1'($urandom_range(0, 1));
            hsize = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                hsel = 1'b1;
                htrans = 2'($urandom_range(0, 1));
            end else begin
                hsel = 1'b0;
                htrans = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
        end
        hsel = 1'b0;
        htrans = 2'd0;
    endtask

    initial begin
        int s0, b0, r0, a0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 8'h00;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // byte writes then a word read
        bsel_q.push_back(4'b0001); xfer(2'd2, 1'b1, 16'h100, 3'd0, 32'h11111111);
        bsel_q.push_back(4'b0010); xfer(2'd2, 1'b1, 16'h101, 3'd0, 32'h22222222);
        bsel_q.push_back(4'b0100); xfer(2'd2, 1'b1, 16'h102, 3'd0, 32'h33333333);
        bsel_q.push_back(4'b1000); xfer(2'd2, 1'b1, 16'h103, 3'd0, 32'h44444444);
        exp_q.push_back(32'h44332211); xfer(2'd2, 1'b0, 16'h100, 3'd2, '0);
        idle(2);

        // back-to-back write then read of another word
        s0 = stall_cnt;
        b0 = both_cnt;
        bsel_q.push_back(4'hF); xfer(2'd2, 1'b1, 16'h20, 3'd2, 32'hDEADBEEF);
        exp_q.push_back(32'h0); xfer(2'd3, 1'b0, 16'h40, 3'd2, '0);
        idle(2);
        check("b2b_same_cycle", both_cnt - b0, 1);
        check("b2b_stalls", stall_cnt - s0, 0);
        exp_q.push_back(32'hDEADBEEF); xfer(2'd2, 1'b0, 16'h20, 3'd2, '0);
        idle(2);

        // read-after-write hazard to the same word
        s0 = stall_cnt;
        bsel_q.push_back(4'hF); xfer(2'd2, 1'b1, 16'h80, 3'd2, 32'hCAFEF00D);
        exp_q.push_back(32'hCAFEF00D); xfer(2'd2, 1'b0, 16'h82, 3'd1, '0);
        idle(3);
        check("hazard_stalls", stall_cnt - s0, 1);

        // reset held three cycles in the middle of a write
        xfer(2'd2, 1'b1, 16'h200, 3'd2, 32'h12345678);
        reset = 1'b0;
        hsel = 1'b0;
        htrans = 2'd0;
        repeat (3) begin
            @(negedge clk);
            check("rst_wr", wr, 0);
            check("rst_rd", rd, 0);
            check("rst_hready", hreadyout, 1);
            check("rst_hresp", hresp, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        exp_q.push_back(32'h0); xfer(2'd2, 1'b0, 16'h200, 3'd2, '0);
        idle(2);

        // IDLE / BUSY / unselected traffic
        a0 = acc_cnt;
        s0 = stall_cnt;
        noise(16);
        idle(1);
        check("noise_access", acc_cnt - a0, 0);
        check("noise_stalls", stall_cnt - s0, 0);

        // misaligned halfword
        s0 = stall_cnt;
        r0 = resp_cnt;
`ifndef AHB_SLAVE_ERR_EN
        bsel_q.push_back(4'b0011);
`endif
        xfer(2'd2, 1'b1, 16'h0001, 3'd1, 32'hA5A5A5A5);
        idle(3);
`ifdef AHB_SLAVE_ERR_EN
        check("err_stalls", stall_cnt - s0, 1);
        check("err_resp_cycles", resp_cnt - r0, 2);
        exp_q.push_back(32'h0);
`else
        check("err_stalls", stall_cnt - s0, 0);
        check("err_resp_cycles", resp_cnt - r0, 0);
        exp_q.push_back(32'h0000A5A5);
`endif
        xfer(2'd2, 1'b0, 16'h0000, 3'd2, '0);
        idle(2);

        // oversize transfer
`ifndef AHB_SLAVE_ERR_EN
        bsel_q.push_back(4'hF);
        exp_q.push_back(32'h0BADF00D);
`else
        exp_q.push_back(32'h0);
`endif
        xfer(2'd2, 1'b1, 16'h300, 3'd3, 32'h0BADF00D);
        idle(3);
        xfer(2'd2, 1'b0, 16'h300, 3'd2, '0);
        idle(3);

        check("exp_q_drained", exp_q.size(), 0);
        check("bsel_q_drained", bsel_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_slave_ctrl.md
# ahb_slave_ctrl

AHB-Lite slave front-end for the on-chip memory stub. It decodes the address phase, builds byte lanes from HSIZE/HADDR, and drives the memory's split read/write strobe port (WR/ADDR_WR/DIN/BSEL, RD/ADDR_RD/DOUT). It returns read data, HREADYOUT and HRESP to the bus. It sits directly upstream of the `*_mem` stub; the stub's registered DOUT, with one-cycle latency, is the read data path.

## Interface
- ADDR_BITS, 16, byte-address width of the memory window
- DATA_BITS, 32, bus/memory data width (32 or 64); BX = DATA_BITS/8 byte lanes
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_BITS  transfer address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, log2 bytes
- HWDATA  in  DATA_BITS  write data (data phase)
- HREADY  in  1  bus ready (previous transfer completing)
- HRDATA  out  DATA_BITS  read data, equals DOUT
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- WR  out  1  memory write strobe
- ADDR_WR  out  ADDR_BITS  memory write byte address
- DIN  out  DATA_BITS  memory write data
- BSEL  out  BX  write byte-lane enables
- RD  out  1  memory read strobe
- ADDR_RD  out  ADDR_BITS  memory read byte address
- DOUT  in  DATA_BITS  registered memory read data

## Operation
- Accept an address phase when HSEL & HTRANS[1] & HREADY. IDLE/BUSY or unselected: zero-wait OKAY, no memory access.
- Lane mask:
  - Computed from HSIZE and HADDR[log2(BX)-1:0], aligned to the size.
  - Byte: 1 lane; half: 2 lanes; word: 4 lanes; dword: 8 lanes (only when DATA_BITS=64).
  - HSIZE above log2(BX) means all lanes (unless the error feature is enabled; see Configuration).
- States: IDLE, WDATA, RDATA, RSTALL, ERR1, ERR2.
- Write accept → WDATA. During WDATA, WR=1 with ADDR_WR/BSEL latched from the address phase and DIN=HWDATA. Zero wait.
- Read accept, no hazard → RD=1 combinationally with ADDR_RD=HADDR → RDATA. HRDATA=DOUT is valid in RDATA, HREADYOUT=1.
- Hazard: a read is accepted while in WDATA and its word address (bits ADDR_BITS-1:log2(BX)) equals the pending write word.
  - RD is suppressed in the accept cycle → RSTALL.
  - RSTALL: HREADYOUT=0, RD=1, ADDR_RD=latched address → RDATA.
- Back-to-back transfers are pipelined. A new accept during WDATA or RDATA selects the next state directly.
- WR and RD asserted in the same cycle to different words is legal.
- Reset mid-operation returns to IDLE. A pending write is dropped and RD/WR are forced 0 while reset=0.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, WR=0, RD=0, ADDR_WR=0, BSEL=0; HRDATA follows DOUT (0 after reset).
- Write: address phase at cycle N, memory updated at the clk edge ending cycle N+1.
- Read: zero-wait, data at cycle N+1. With the hazard, one wait state: HREADYOUT=0 at N+1, data valid at N+2 and includes the just-written bytes.
- HREADYOUT is a registered state decode; no combinational path from HADDR to HREADYOUT.

## Configuration
- AHB_SLAVE_ERR_EN defined:
  - HSIZE above log2(BX), or an address misaligned to HSIZE, is rejected.
  - No RD/WR is issued; ERR1 (HREADYOUT=0, HRESP=1) → ERR2 (HREADYOUT=1, HRESP=1) → IDLE or next accept.
- Undefined:
  - Oversize transfers use all lanes at the word address.
  - Misaligned low bits are ignored for lane selection, i.e. the size-aligned address is used.
  - HRESP is tied 0, and ERR1/ERR2 are not built.

## Test plan
- Reset: hold reset=0 for 3 cycles mid-write → WR=0, HREADYOUT=1, HRESP=0; the write never lands (read back = 0x00000000).
- Byte writes: write 0x11/0x22/0x33/0x44 to 0x100–0x103 with HSIZE=0 → BSEL 0001/0010/0100/1000; word read of 0x100 = 0x44332211.
- Back-to-back: NONSEQ write 0xDEADBEEF @0x20, then SEQ read @0x40 → WR and RD in the same cycle, zero wait states.
- Hazard: write 0xCAFEF00D @0x80 immediately followed by read @0x82 → one cycle HREADYOUT=0, then HRDATA=0xCAFEF00D.
- IDLE/BUSY/HSEL=0 traffic with random HADDR → no WR/RD, HREADYOUT=1, HRESP=0.
- Error (AHB_SLAVE_ERR_EN): HSIZE=1 @0x0001 → two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 both), memory unchanged. Without the macro: same access writes lanes 0011.
